dff_reg_share_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for one shared W-bit storage register (a bank of D flip-flops with q/qbar outputs).
- N requesters compete for exclusive write ownership. The block grants one at a time, gates writes from the owner only, and bounds ownership with a hold timeout.
- Sits between requester logic and the shared register bank; the bank is instantiated inside this block.

---
 rtl/dff_reg_share_arbiter.sv | 115 +++++++++++
 tb/tb_dff_reg_share_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_reg_share_arbiter.sv
// Round-robin write-ownership arbiter in front of one shared W-bit register bank.
// One requester owns the bank at a time; ownership ends on request drop or after MAX_HOLD cycles.
module dff_reg_share_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         we,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout,
    output logic [W-1:0]         q,
    output logic [W-1:0]         qbar
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] rr;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [N-1:0]  win_onehot;
    logic [W-1:0]  wsel;

    // First set request at or above the rr pointer, wrapping N-1 -> 0.
    always_comb begin : rr_search
        logic [IW:0] sum;
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!win_vld && req[sum[IW-1:0]]) begin
                win_vld = 1'b1;
                win     = sum[IW-1:0];
            end
        end
    end

    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;

    always_comb begin
        wsel = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                wsel = wdata[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner    <= '0;
            timeout  <= 1'b0;
            rr       <= '0;
            hold_cnt <= '0;
            q        <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state    <= ST_GRANT;
                        gnt      <= win_onehot;
                        owner    <= win;
                        hold_cnt <= '0;
                        rr       <= (win == IW'(N-1)) ? '0 : win + 1'b1;
                    end
                end
                ST_GRANT: begin
                    // A write coinciding with release still commits.
                    if (we[owner]) begin
                        q <= wsel;
                    end
                    if (!req[owner]) begin
                        state <= ST_RELEASE;
                        gnt   <= '0;
                    end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        state   <= ST_RELEASE;
                        gnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_GRANT);
    assign qbar = ~q;

endmodule

// File: tb/tb_dff_reg_share_arbiter.sv
// Directed bench for dff_reg_share_arbiter: reset, rotation, timeout, write gating,
// reset during a write, and pointer wrap-around, checked with immediate assertions.
module tb_dff_reg_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic           timeout;
    logic [W-1:0]   q;
    logic [W-1:0]   qbar;

    int vectors;
    int miscompares;

    dff_reg_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .we      (we),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout),
        .q       (q),
        .qbar    (qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        wdata = '0;

        // Reset state
        do_reset();
        chk("rst_gnt",     32'(gnt),     32'h0);
        chk("rst_owner",   32'(owner),   32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_q",       32'(q),       32'h00);
        chk("rst_qbar",    32'(qbar),    32'hFF);

        // Single request with write
        req   = 4'b0001;
        we    = 4'b0001;
        wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
        tick();
        chk("t1_gnt",  32'(gnt),  32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_q_pre", 32'(q),   32'h00);
        tick();
        chk("t1_q",    32'(q),    32'hA5);
        chk("t1_qbar", 32'(qbar), 32'h5A);
        req = '0;
        we  = '0;
        tick();
        chk("t1_rel_gnt", 32'(gnt), 32'h0);
        chk("t1_q_hold",  32'(q),   32'hA5);
        tick();

        // Round-robin rotation with req=1111
        do_reset();
        req   = 4'b1111;
        wdata = '0;
        for (int i = 0; i < 5; i++) begin
            int e;
            e = i % 4;
            tick();
            chk("t2_gnt",   32'(gnt),   32'(1) << e);
            chk("t2_owner", 32'(owner), 32'(e));
            tick();
            tick();
            chk("t2_hold_gnt", 32'(gnt), 32'(1) << e);
            req = 4'b1111 & ~(4'(1) << e);
            tick();
            chk("t2_release_gnt",  32'(gnt),  32'h0);
            chk("t2_release_busy", 32'(busy), 32'h0);
            req = 4'b1111;
            tick();
            chk("t2_idle_gnt", 32'(gnt), 32'h0);
        end
        req = '0;
        tick();

        // Timeout with req=0010 held
        req = 4'b0010;
        tick();
        chk("t3_gnt0", 32'(gnt), 32'h2);
        for (int c = 1; c < MAX_HOLD; c++) begin
            tick();
            chk("t3_gnt_held", 32'(gnt),     32'h2);
            chk("t3_no_to",    32'(timeout), 32'h0);
        end
        tick();
        chk("t3_forced_gnt", 32'(gnt),     32'h0);
        chk("t3_timeout",    32'(timeout), 32'h1);
        tick();
        chk("t3_dead_gnt",  32'(gnt),     32'h0);
        chk("t3_to_pulse",  32'(timeout), 32'h0);
        tick();
        chk("t3_regrant", 32'(gnt), 32'h2);
        req = '0;
        tick();
        tick();

        // Write gating: owner 2 among all-strobing requesters
        req   = 4'b0100;
        we    = 4'b1111;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        chk("t4_owner",  32'(owner), 32'h2);
        chk("t4_q_idle", 32'(q),     32'h00);
        tick();
        chk("t4_q",    32'(q),    32'h33);
        chk("t4_qbar", 32'(qbar), 32'hCC);
        tick();
        chk("t4_q2", 32'(q), 32'h33);
        req = '0;
        we  = '0;
        tick();
        tick();

        // Reset during a granted write by owner 3
        req = 4'b1000;
        tick();
        chk("t5_owner", 32'(owner), 32'h3);
        rst_n = 1'b0;
        we    = 4'b1000;
        wdata = {8'hFF, 8'h00, 8'h00, 8'h00};
        tick();
        chk("t5_gnt",   32'(gnt),   32'h0);
        chk("t5_q",     32'(q),     32'h00);
        chk("t5_qbar",  32'(qbar),  32'hFF);
        chk("t5_busy",  32'(busy),  32'h0);
        chk("t5_owner0", 32'(owner), 32'h0);
        rst_n = 1'b1;
        we    = '0;
        req   = 4'b1111;
        tick();
        chk("t5_rr0", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();

        // Wrap-around: grant 2, then req=0011 goes to 0 then 1
        req = 4'b0100;
        tick();
        chk("t6_gnt2", 32'(gnt), 32'h4);
        req = '0;
        tick();
        tick();
        req = 4'b0011;
        tick();
        chk("t6_wrap0",  32'(gnt),   32'h1);
        chk("t6_owner0", 32'(owner), 32'h0);
        req = 4'b0010;
        tick();
        tick();
        tick();
        chk("t6_next1",  32'(gnt),   32'h2);
        chk("t6_owner1", 32'(owner), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
